// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Each access runs IDLE -> WAIT -> RESP and ends in a one-cycle valid pulse to its owner.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,

    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [3:0]  dm_wstrb,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_valid,

    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,

    output logic        stall_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } owner_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      r_state;
    owner_t      r_owner;
    owner_t      r_last_grant;
    logic [7:0]  r_cnt;

    logic        r_mem_req;
    logic        r_mem_we;
    logic [3:0]  r_mem_wstrb;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;

    logic [31:0] r_if_rdata;
    logic        r_if_valid;
    logic [31:0] r_dm_rdata;
    logic        r_dm_valid;
    logic        r_err;

    logic        w_grant_any;
    logic        w_grant_dm;
    logic [31:0] w_ack_data;

    assign w_grant_any = if_req | dm_req;
    // Under contention the requester that did not win last time is served.
    assign w_grant_dm  = dm_req & (~if_req | (r_last_grant == OWN_IF));
    assign w_ack_data  = r_mem_we ? '0 : mem_rdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_IF;
            r_last_grant <= OWN_IF;
            r_cnt        <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_wstrb  <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_if_rdata   <= '0;
            r_if_valid   <= 1'b0;
            r_dm_rdata   <= '0;
            r_dm_valid   <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_if_valid <= 1'b0;
            r_dm_valid <= 1'b0;
            r_err      <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_grant_any) begin
                        r_mem_req <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= ST_WAIT;
                        if (w_grant_dm) begin
                            r_owner      <= OWN_DM;
                            r_last_grant <= OWN_DM;
                            r_mem_we     <= dm_we;
                            r_mem_wstrb  <= dm_we ? dm_wstrb : 4'b0000;
                            r_mem_addr   <= dm_addr;
                            r_mem_wdata  <= dm_wdata;
                        end else begin
                            r_owner      <= OWN_IF;
                            r_last_grant <= OWN_IF;
                            r_mem_we     <= 1'b0;
                            r_mem_wstrb  <= 4'b0000;
                            r_mem_addr   <= if_addr;
                            r_mem_wdata  <= '0;
                        end
                    end
                end

                ST_WAIT: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_RESP;
                        if (r_owner == OWN_DM) begin
                            r_dm_rdata <= w_ack_data;
                            r_dm_valid <= 1'b1;
                        end else begin
                            r_if_rdata <= w_ack_data;
                            r_if_valid <= 1'b1;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        // Abort: complete the access towards the owner with zero data and an error.
                        r_mem_req <= 1'b0;
                        r_err     <= 1'b1;
                        r_state   <= ST_RESP;
                        if (r_owner == OWN_DM) begin
                            r_dm_rdata <= '0;
                            r_dm_valid <= 1'b1;
                        end else begin
                            r_if_rdata <= '0;
                            r_if_valid <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                ST_RESP: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_wstrb = r_mem_wstrb;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    assign if_rdata  = r_if_rdata;
    assign if_valid  = r_if_valid;
    assign dm_rdata  = r_dm_rdata;
    assign dm_valid  = r_dm_valid;
    assign err_o     = r_err;

    assign stall_o   = (if_req & ~r_if_valid) | (dm_req & ~r_dm_valid);

endmodule
